panel_row_buffer: RTL and testbench

- Downstream consumer of usb_controller's chunk write port (chunk_data/chunk_addr/chunk_write_enable/row_addr/panel_addr).
- Assembles one 512-bit row (16 x 32-bit chunks) in a ping-pong buffer.
- Serialises each committed row MSB-first to the panel LED-driver chain (sclk/sin/xlat), then reports which panel/row was latched.
- The next row fills while the previous row shifts out.

---
 rtl/panel_pkg.sv | 27 ++
 rtl/panel_shift_out.sv | 119 +++++++++++
 rtl/panel_row_buffer.sv | 111 +++++++++++
 tb/tb_panel_row_buffer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
// panel_pkg: shared constants, row tag bundle and shifter states for the
// panel row buffer and its serial shift-out stage.
package panel_pkg;

    localparam int CHUNKS_PER_ROW = 16;
    localparam int CHUNK_WIDTH    = 32;
    localparam int ROW_BITS       = CHUNKS_PER_ROW * CHUNK_WIDTH;
    localparam int CHUNK_AW       = $clog2(CHUNKS_PER_ROW);
    localparam int BIT_IN_AW      = $clog2(CHUNK_WIDTH);
    localparam int BIT_AW         = $clog2(ROW_BITS);
    localparam int ROW_AW         = 4;
    localparam int PANEL_AW       = 2;

    typedef struct packed {
        logic [ROW_AW-1:0]   row;
        logic [PANEL_AW-1:0] panel;
    } row_tag_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH
    } shift_state_t;

endpackage

// File: rtl/panel_shift_out.sv
// panel_shift_out: serialises one committed row MSB-first onto sclk/sin and
// pulses xlat. Ports: clk, reset, start, rd_idx/rd_data chunk read port,
// busy, done (first latch cycle), sclk, sin, xlat.
module panel_shift_out
    import panel_pkg::*;
#(
    parameter int SCLK_DIV = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [CHUNK_AW-1:0]    rd_idx,
    input  logic [CHUNK_WIDTH-1:0] rd_data,
    output logic                   busy,
    output logic                   done,
    output logic                   sclk,
    output logic                   sin,
    output logic                   xlat
);

    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    shift_state_t state, state_d;

    logic [DIV_W-1:0]       cnt, cnt_d;
    logic [BIT_AW-1:0]      bit_cnt, bit_d;
    logic [CHUNK_WIDTH-1:0] sreg, sreg_d;

    logic last_div;
    logic chunk_end;
    logic row_end;

    assign last_div  = (cnt == DIV_W'(SCLK_DIV - 1));
    assign chunk_end = (bit_cnt[BIT_IN_AW-1:0] == '1);
    assign row_end   = (bit_cnt == BIT_AW'(ROW_BITS - 1));
    assign busy      = (state != ST_IDLE);

    // Chunk 0 is fetched in LOAD; while shifting, the next chunk is
    // presented so it is ready on the chunk boundary.
    assign rd_idx = (state == ST_LOAD) ? '0 :
        bit_cnt[BIT_AW-1:BIT_IN_AW] + CHUNK_AW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            sreg    <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_cnt <= bit_d;
            sreg    <= sreg_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        bit_d   = bit_cnt;
        sreg_d  = sreg;
        done    = 1'b0;
        sclk    = 1'b0;
        sin     = 1'b0;
        xlat    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                sreg_d  = rd_data;
                bit_d   = '0;
                cnt_d   = '0;
                state_d = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                sin = sreg[CHUNK_WIDTH-1];
                if (last_div) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT_HI;
                end else begin
                    cnt_d = cnt + DIV_W'(1);
                end
            end
            ST_SHIFT_HI: begin
                sclk = 1'b1;
                sin  = sreg[CHUNK_WIDTH-1];
                if (last_div) begin
                    cnt_d = '0;
                    if (row_end) begin
                        state_d = ST_LATCH;
                    end else begin
                        bit_d   = bit_cnt + BIT_AW'(1);
                        sreg_d  = chunk_end ? rd_data :
                            {sreg[CHUNK_WIDTH-2:0], 1'b0};
                        state_d = ST_SHIFT_LO;
                    end
                end else begin
                    cnt_d = cnt + DIV_W'(1);
                end
            end
            ST_LATCH: begin
                xlat = 1'b1;
                done = (cnt == '0);
                if (cnt == DIV_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + DIV_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/panel_row_buffer.sv
// panel_row_buffer: assembles 16x32-bit chunks into a ping-pong row buffer
// and hands committed rows to panel_shift_out. Ports: chunk write port in,
// row_buf_full/busy/overrun status, sclk/sin/xlat, latched row/panel out.
module panel_row_buffer
    import panel_pkg::*;
#(
    parameter int SCLK_DIV = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CHUNK_WIDTH-1:0] chunk_data,
    input  logic [CHUNK_AW-1:0]    chunk_addr,
    input  logic                   chunk_write_enable,
    input  logic [ROW_AW-1:0]      row_addr,
    input  logic [PANEL_AW-1:0]    panel_addr,
    output logic                   row_buf_full,
    output logic                   busy,
    output logic                   overrun,
    input  logic                   overrun_clear,
    output logic                   sclk,
    output logic                   sin,
    output logic                   xlat,
    output logic [ROW_AW-1:0]      out_row_addr,
    output logic [PANEL_AW-1:0]    out_panel_addr
);

    logic [CHUNK_WIDTH-1:0] bank [2][CHUNKS_PER_ROW];

    logic     wr_bank;
    logic     rbf_q;
    logic     overrun_q;
    row_tag_t pend;
    row_tag_t shift_tag;
    row_tag_t out_tag;

    logic wr_ok;
    logic drop;
    logic commit;
    logic swap;
    logic sh_busy;
    logic sh_done;

    logic [CHUNK_AW-1:0]    rd_idx;
    logic [CHUNK_WIDTH-1:0] rd_data;

    assign wr_ok  = chunk_write_enable & ~rbf_q;
    assign drop   = chunk_write_enable & rbf_q;
    assign commit = wr_ok &
        (chunk_addr == CHUNK_AW'(CHUNKS_PER_ROW - 1));
    // The shifter only takes a row from IDLE; the same edge flips banks.
    assign swap   = rbf_q & ~sh_busy;

    assign rd_data = bank[~wr_bank][rd_idx];

    assign row_buf_full   = rbf_q;
    assign busy           = sh_busy;
    assign overrun        = overrun_q;
    assign out_row_addr   = out_tag.row;
    assign out_panel_addr = out_tag.panel;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            bank[wr_bank][chunk_addr] <= chunk_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank   <= 1'b0;
            rbf_q     <= 1'b0;
            overrun_q <= 1'b0;
            pend      <= '0;
            shift_tag <= '0;
            out_tag   <= '0;
        end else begin
            if (commit) begin
                rbf_q <= 1'b1;
                pend  <= '{row: row_addr, panel: panel_addr};
            end else if (swap) begin
                rbf_q     <= 1'b0;
                wr_bank   <= ~wr_bank;
                shift_tag <= pend;
            end
            // Set wins over clear in the same cycle.
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (overrun_clear) begin
                overrun_q <= 1'b0;
            end
            if (sh_done) begin
                out_tag <= shift_tag;
            end
        end
    end

    panel_shift_out #(
        .SCLK_DIV(SCLK_DIV)
    ) u_shift (
        .clk    (clk),
        .reset  (reset),
        .start  (swap),
        .rd_idx (rd_idx),
        .rd_data(rd_data),
        .busy   (sh_busy),
        .done   (sh_done),
        .sclk   (sclk),
        .sin    (sin),
        .xlat   (xlat)
    );

endmodule

// File: tb/tb_panel_row_buffer.sv
// tb_panel_row_buffer: self-checking bench for panel_row_buffer.
// Table-driven rows, hand corner sequences, random rows vs a row-image model.
`timescale 1ns/1ps
module tb_panel_row_buffer;

    localparam int SD = 2;
    localparam int BUSY_LEN = 1 + 512 * 2 * SD + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] chunk_data;
    logic [3:0]  chunk_addr;
    logic        chunk_write_enable;
    logic [3:0]  row_addr;
    logic [1:0]  panel_addr;
    logic        row_buf_full;
    logic        busy;
    logic        overrun;
    logic        overrun_clear;
    logic        sclk;
    logic        sin;
    logic        xlat;
    logic [3:0]  out_row_addr;
    logic [1:0]  out_panel_addr;

    panel_row_buffer #(.SCLK_DIV(SD)) dut (
        .clk               (clk),
        .reset             (reset),
        .chunk_data        (chunk_data),
        .chunk_addr        (chunk_addr),
        .chunk_write_enable(chunk_write_enable),
        .row_addr          (row_addr),
        .panel_addr        (panel_addr),
        .row_buf_full      (row_buf_full),
        .busy              (busy),
        .overrun           (overrun),
        .overrun_clear     (overrun_clear),
        .sclk              (sclk),
        .sin               (sin),
        .xlat              (xlat),
        .out_row_addr      (out_row_addr),
        .out_panel_addr    (out_panel_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] bits;
        logic [3:0]   row;
        logic [1:0]   panel;
    } exp_t;

    typedef struct {
        logic [31:0] fill;
        logic [3:0]  row;
        logic [1:0]  panel;
        int          ones;
        logic        first;
        logic        last;
    } vec_t;

    int total = 0;
    int bad = 0;

    logic [31:0] mbank [2][16];
    bit          mwb = 1'b0;
    exp_t        exp_q[$];

    logic [511:0] cap_vec = '0;
    logic [511:0] last_bits = '0;
    int cap_n = 0;
    int sclk_rises = 0;
    int lat_starts = 0;
    int events = 0;
    int xlen = 0;
    int busy_run = 0;
    int idle_run = 0;
    int last_busy = 0;
    int last_idle = 0;
    bit sclk_q = 0;
    bit xlat_q = 0;
    bit busy_q = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] row_image(input bit b);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[511 - 32 * i -: 32] = mbank[b][i];
        return v;
    endfunction

    // Monitor: samples settled outputs shortly after each rising edge.
    always begin
        @(posedge clk);
        #2;
        if (busy === 1'b1) begin
            if (!busy_q) begin
                last_idle = idle_run;
                busy_run = 0;
            end
            busy_run++;
        end else begin
            if (busy_q) begin
                last_busy = busy_run;
                idle_run = 0;
            end
            idle_run++;
        end
        busy_q = (busy === 1'b1);
        if (reset) begin
            cap_n = 0;
            xlen = 0;
            sclk_q = 0;
            xlat_q = 0;
        end else begin
            if (sclk && !sclk_q) begin
                cap_vec = {cap_vec[510:0], sin};
                cap_n++;
                sclk_rises++;
            end
            if (xlat) begin
                xlen++;
                if (!xlat_q) begin
                    lat_starts++;
                end else if (xlen == 2) begin
                    exp_t e;
                    chk("bit_count", cap_n, 512);
                    chk("latch_sclk_sin", {sclk, sin}, 2'b00);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_latch", lat_starts, 0);
                    end else begin
                        e = exp_q.pop_front();
                        total++;
                        if (cap_vec !== e.bits) begin
                            bad++;
                            $display("FAIL row_bits: got %h want %h",
                                     cap_vec, e.bits);
                        end
                        chk("out_row", out_row_addr, e.row);
                        chk("out_panel", out_panel_addr, e.panel);
                    end
                    last_bits = cap_vec;
                    cap_n = 0;
                    events++;
                end
            end else if (xlat_q) begin
                chk("xlat_width", xlen, 2);
                xlen = 0;
            end
            sclk_q = sclk;
            xlat_q = xlat;
        end
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] r, input logic [1:0] p,
                      input bit drop);
        exp_t e;
        chunk_addr = a;
        chunk_data = d;
        row_addr = r;
        panel_addr = p;
        chunk_write_enable = 1'b1;
        @(negedge clk);
        chunk_write_enable = 1'b0;
        if (!drop) begin
            mbank[mwb][a] = d;
            if (a == 4'd15) begin
                e.bits = row_image(mwb);
                e.row = r;
                e.panel = p;
                exp_q.push_back(e);
                mwb = ~mwb;
            end
        end
    endtask

    task automatic wr_rand_row(input logic [3:0] r, input logic [1:0] p);
        for (int c = 0; c < 16; c++) wr(4'(c), $urandom, r, p, 0);
    endtask

    task automatic wait_busy(input logic lvl, input string nm);
        int n = 0;
        while (busy !== lvl && n < 12000) begin
            @(negedge clk);
            n++;
        end
        if (busy !== lvl) chk(nm, busy, lvl);
    endtask

    task automatic wait_rbf_low(input string nm);
        int n = 0;
        while (row_buf_full !== 1'b0 && n < 12000) begin
            @(negedge clk);
            n++;
        end
        if (row_buf_full !== 1'b0) chk(nm, row_buf_full, 0);
    endtask

    task automatic wait_events(input int target, input string nm);
        int n = 0;
        while (events < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (events < target) chk(nm, events, target);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vec_t vt [4];
        int ev0;
        int ls0;
        int sc0;
        int n;
        bit held;
        bit px;
        int perm [15];

        vt[0] = '{32'h8000_0001, 4'd3, 2'd2, 32, 1'b1, 1'b1};
        vt[1] = '{32'hFFFF_FFFF, 4'd5, 2'd1, 512, 1'b1, 1'b1};
        vt[2] = '{32'h0000_0000, 4'd6, 2'd0, 0, 1'b0, 1'b0};
        vt[3] = '{32'h0000_FFFF, 4'd9, 2'd3, 256, 1'b0, 1'b1};

        reset = 1'b1;
        chunk_data = '0;
        chunk_addr = '0;
        chunk_write_enable = 1'b0;
        row_addr = '0;
        panel_addr = '0;
        overrun_clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {sclk, sin, xlat, busy, row_buf_full, overrun}, 0);
        chk("rst_addr", {out_row_addr, out_panel_addr}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven full rows.
        for (int k = 0; k < 4; k++) begin
            wait_busy(0, "tbl_idle");
            ev0 = events;
            for (int c = 0; c < 16; c++)
                wr(4'(c), vt[k].fill, vt[k].row, vt[k].panel, 0);
            chk("commit_full", row_buf_full, 1);
            chk("commit_busy", busy, 0);
            @(negedge clk);
            chk("start_busy", busy, 1);
            chk("start_rbf", row_buf_full, 0);
            wait_events(ev0 + 1, "tbl_latch");
            chk("tbl_ones", $countones(last_bits), vt[k].ones);
            chk("tbl_first", last_bits[511], vt[k].first);
            chk("tbl_last", last_bits[0], vt[k].last);
            chk("tbl_row", out_row_addr, vt[k].row);
            chk("tbl_panel", out_panel_addr, vt[k].panel);
            wait_busy(0, "tbl_end");
            @(negedge clk);
            chk("busy_len", last_busy, BUSY_LEN);
        end

        // Ping-pong: second row fills while the first shifts.
        ev0 = events;
        ls0 = lat_starts;
        for (int c = 0; c < 16; c++) wr(4'(c), 32'hFFFF_FFFF, 4'd5, 2'd0, 0);
        wait_busy(1, "pp_start");
        for (int c = 0; c < 16; c++) wr(4'(c), 32'h0, 4'd6, 2'd1, 0);
        chk("pp_full", row_buf_full, 1);
        held = 1;
        n = 0;
        while (events < ev0 + 1 && n < 10000) begin
            if (row_buf_full !== 1'b1) held = 0;
            @(negedge clk);
            n++;
        end
        chk("pp_held", held, 1);
        wait_events(ev0 + 2, "pp_latch");
        chk("pp_row", out_row_addr, 6);
        chk("pp_zeros", $countones(last_bits), 0);
        chk("pp_gap", last_idle, 1);
        chk("pp_xlats", lat_starts - ls0, 2);
        chk("pp_ovr", overrun, 0);

        // Overrun and drop handling with a held pending row.
        wait_busy(0, "ov_idle");
        ev0 = events;
        wr_rand_row(4'd10, 2'd1);
        wait_busy(1, "ov_start");
        wr_rand_row(4'd11, 2'd2);
        wr(4'd7, 32'hDEAD_BEEF, 4'd1, 2'd1, 1);
        chk("ov_set", overrun, 1);
        chk("ov_full", row_buf_full, 1);
        overrun_clear = 1'b1;
        @(negedge clk);
        overrun_clear = 1'b0;
        chk("ov_clear", overrun, 0);
        overrun_clear = 1'b1;
        wr(4'd3, 32'h1234_5678, 4'd1, 2'd1, 1);
        overrun_clear = 1'b0;
        chk("ov_set_wins", overrun, 1);
        wr(4'd15, 32'hCAFE_F00D, 4'd2, 2'd3, 1);
        chk("ov_commit_drop", overrun, 1);
        chk("ov_still_full", row_buf_full, 1);
        overrun_clear = 1'b1;
        @(negedge clk);
        overrun_clear = 1'b0;
        chk("ov_clear2", overrun, 0);
        wait_events(ev0 + 2, "ov_latch");
        chk("ov_row", out_row_addr, 11);

        // Commit landing on the final LATCH edge.
        wait_busy(0, "ll_idle");
        ev0 = events;
        wr_rand_row(4'd12, 2'd0);
        wait_busy(1, "ll_start");
        sc0 = sclk_rises;
        for (int c = 0; c < 15; c++) wr(4'(c), $urandom, 4'd13, 2'd3, 0);
        px = 0;
        n = 0;
        while (!(xlat === 1'b1 && px) && n < 12000) begin
            px = (xlat === 1'b1);
            @(negedge clk);
            n++;
        end
        chk("ll_found", xlat, 1);
        wr(4'd15, $urandom, 4'd13, 2'd3, 0);
        chk("ll_full", row_buf_full, 1);
        chk("ll_idle1", busy, 0);
        @(negedge clk);
        chk("ll_restart", busy, 1);
        wait_events(ev0 + 2, "ll_latch");
        chk("ll_gap", last_idle, 1);
        chk("ll_sclks", sclk_rises - sc0, 1024);

        // Partially written row shifts stale bank contents.
        wait_busy(0, "st_idle");
        ev0 = events;
        wr(4'd2, $urandom, 4'd14, 2'd2, 0);
        wr(4'd15, $urandom, 4'd14, 2'd2, 0);
        wait_events(ev0 + 1, "st_latch");

        // Random rows: shuffled order with rewrites before commit.
        ev0 = events;
        for (int r = 0; r < 3; r++) begin
            logic [3:0] ra;
            logic [1:0] pa;
            ra = 4'($urandom_range(15, 0));
            pa = 2'($urandom_range(3, 0));
            wait_rbf_low("rnd_wait");
            for (int i = 0; i < 15; i++) perm[i] = i;
            for (int i = 14; i > 0; i--) begin
                int j;
                int t;
                j = $urandom_range(i, 0);
                t = perm[i];
                perm[i] = perm[j];
                perm[j] = t;
            end
            for (int i = 0; i < 15; i++) wr(4'(perm[i]), $urandom, ra, pa, 0);
            for (int i = 0; i < 4; i++)
                wr(4'($urandom_range(14, 0)), $urandom, ra, pa, 0);
            wr(4'd15, $urandom, ra, pa, 0);
        end
        wait_events(ev0 + 3, "rnd_latch");
        chk("rnd_ovr", overrun, 0);

        // Reset in the middle of a shift.
        wait_busy(0, "rs_idle");
        wr_rand_row(4'd7, 2'd3);
        wait_busy(1, "rs_start");
        repeat (1000) @(negedge clk);
        ls0 = lat_starts;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        exp_q.delete();
        mwb = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rs_sclk", sclk, 0);
        chk("rs_sin", sin, 0);
        chk("rs_xlat", xlat, 0);
        chk("rs_busy", busy, 0);
        chk("rs_rbf", row_buf_full, 0);
        chk("rs_row", out_row_addr, 0);
        chk("rs_panel", out_panel_addr, 0);
        repeat (60) @(negedge clk);
        chk("rs_no_xlat", lat_starts, ls0);
        chk("rs_busy_after", busy, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
